// File: rtl/usb_cdc_stream_agent.sv
// rtl/usb_cdc_stream_agent.sv - byte-stream loopback/generator/checker/sink agent for usb_cdc_core ports
module usb_cdc_stream_agent #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         CNT_W      = 16,
  parameter logic [7:0] SEED       = 8'h00,
  parameter int         GEN_LEN    = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    mode_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic                          outport_valid_i,
  input  logic [7:0]                    outport_data_i,
  output logic                          outport_accept_o,
  output logic                          inport_valid_o,
  output logic [7:0]                    inport_data_o,
  input  logic                          inport_accept_i,
  output logic [CNT_W-1:0]              rx_count_o,
  output logic [CNT_W-1:0]              tx_count_o,
  output logic [CNT_W-1:0]              err_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [1:0] MODE_LOOP = 2'd0;
  localparam logic [1:0] MODE_GEN  = 2'd1;
  localparam logic [1:0] MODE_CHK  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DRAIN} state_t;

  logic [1:0]       r_mode_q;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [7:0]       r_gen_byte;
  logic [CNT_W-1:0] r_gen_left;
  logic [7:0]       r_expected;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic       w_mode_chg;
  logic       w_full;
  logic       w_empty;
  logic       w_accept;
  logic       w_valid;
  logic       w_rx_xfer;
  logic       w_tx_xfer;
  logic       w_gen_push;
  logic       w_gen_load;
  logic       w_push;
  logic [7:0] w_push_data;
  logic       w_mismatch;

  // A mode switch spends one cycle with both ports stalled while state is flushed.
  assign w_mode_chg = (mode_i != r_mode_q);
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);

  // Port handshake qualifiers; accept never looks at outport_valid_i.
  always_comb begin
    w_accept = 1'b0;
    w_valid  = 1'b0;
    if (!rst_i && !w_mode_chg) begin
      case (r_mode_q)
        MODE_LOOP: begin
          w_accept = !w_full;
          w_valid  = !w_empty;
        end
        MODE_GEN: begin
          w_accept = 1'b1;
          w_valid  = !w_empty;
        end
        default: w_accept = 1'b1;
      endcase
    end
  end

  assign w_rx_xfer   = outport_valid_i && w_accept;
  assign w_tx_xfer   = w_valid && inport_accept_i;
  assign w_push      = ((r_mode_q == MODE_LOOP) && w_rx_xfer) || w_gen_push;
  assign w_push_data = w_gen_push ? r_gen_byte : outport_data_i;
  assign w_mismatch  = (r_mode_q == MODE_CHK) && w_rx_xfer && (outport_data_i != r_expected);

  // Generator next-state: start only from IDLE in generator mode, drain before going idle.
  always_comb begin
    w_state_nxt = r_state;
    w_gen_push  = 1'b0;
    w_gen_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_mode_q == MODE_GEN) && start_i) begin
          w_state_nxt = ST_GEN;
          w_gen_load  = 1'b1;
        end
      end
      ST_GEN: begin
        if (!w_full) begin
          w_gen_push = 1'b1;
          if (r_gen_left == CNT_W'(1)) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_mode_chg) begin
      w_state_nxt = ST_IDLE;
      w_gen_push  = 1'b0;
      w_gen_load  = 1'b0;
    end
  end

  // Generator state register; mode_q tracks mode_i every cycle including reset.
  always_ff @(posedge clk_i) begin
    r_mode_q <= mode_i;
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Generator byte value and remaining-length counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gen_byte <= SEED;
      r_gen_left <= '0;
    end else if (w_gen_load) begin
      r_gen_byte <= SEED;
      r_gen_left <= CNT_W'(GEN_LEN);
    end else if (w_gen_push) begin
      r_gen_byte <= r_gen_byte + 8'd1;
      r_gen_left <= r_gen_left - CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy; reset and mode change both empty it.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_mode_chg) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_tx_xfer) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_tx_xfer})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // Checker expectation: advance on match, resync to the received byte on mismatch.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_mode_chg) begin
      r_expected <= SEED;
    end else if ((r_mode_q == MODE_CHK) && w_rx_xfer) begin
      if (w_mismatch) begin
        r_expected <= outport_data_i + 8'd1;
      end else begin
        r_expected <= r_expected + 8'd1;
      end
    end
  end

  // Saturating traffic/error counters; clear beats a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_rx_cnt  <= '0;
      r_tx_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_rx_xfer && (r_rx_cnt != '1)) begin
        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      end
      if (w_tx_xfer && (r_tx_cnt != '1)) begin
        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      end
      if (w_mismatch && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign outport_accept_o = w_accept;
  assign inport_valid_o   = w_valid;
  assign inport_data_o    = w_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign rx_count_o       = r_rx_cnt;
  assign tx_count_o       = r_tx_cnt;
  assign err_count_o      = r_err_cnt;
  assign level_o          = r_count;
  assign busy_o           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb_cdc_stream_agent.sv
// tb/tb_usb_cdc_stream_agent.sv - directed self-checking bench for usb_cdc_stream_agent
module tb_usb_cdc_stream_agent;

  localparam int         FIFO_DEPTH = 16;
  localparam int         CNT_W      = 5;
  localparam logic [7:0] SEED       = 8'h05;
  localparam int         GEN_LEN    = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [1:0]       mode_i = 2'd0;
  logic             start_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             outport_valid_i = 1'b0;
  logic [7:0]       outport_data_i = 8'h00;
  logic             outport_accept_o;
  logic             inport_valid_o;
  logic [7:0]       inport_data_o;
  logic             inport_accept_i = 1'b0;
  logic [CNT_W-1:0] rx_count_o;
  logic [CNT_W-1:0] tx_count_o;
  logic [CNT_W-1:0] err_count_o;
  logic [4:0]       level_o;
  logic             busy_o;

  int         n_vec = 0;
  int         n_miscmp = 0;
  logic [7:0] out_q[$];
  bit         ok;

  usb_cdc_stream_agent #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W),
    .SEED       (SEED),
    .GEN_LEN    (GEN_LEN)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mode_i           (mode_i),
    .start_i          (start_i),
    .clear_i          (clear_i),
    .outport_valid_i  (outport_valid_i),
    .outport_data_i   (outport_data_i),
    .outport_accept_o (outport_accept_o),
    .inport_valid_o   (inport_valid_o),
    .inport_data_o    (inport_data_o),
    .inport_accept_i  (inport_accept_i),
    .rx_count_o       (rx_count_o),
    .tx_count_o       (tx_count_o),
    .err_count_o      (err_count_o),
    .level_o          (level_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs settle 1 ns after posedge, so the negedge view is what the next posedge transfers.
  always @(negedge clk_i) begin
    if (inport_valid_o && inport_accept_i) out_q.push_back(inport_data_o);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int budget, output bit done);
    outport_valid_i = 1'b1;
    outport_data_i  = d;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      #2;
      if (outport_accept_o) done = 1'b1;
      @(posedge clk_i);
      #1;
    end
    outport_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] e;
    check_eq({tag, "_len"}, out_q.size(), n);
    e = first;
    for (int i = 0; i < n; i++) begin
      if (i < out_q.size()) check_eq({tag, "_byte"}, out_q[i], e);
      e = e + step;
    end
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (out_q.size() >= n) break;
      tick();
    end
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    #2;
    check_eq("rst_accept", outport_accept_o, 0);
    check_eq("rst_valid", inport_valid_o, 0);
    check_eq("rst_data", inport_data_o, 0);
    check_eq("rst_rx", rx_count_o, 0);
    check_eq("rst_tx", tx_count_o, 0);
    check_eq("rst_level", level_o, 0);
    check_eq("rst_busy", busy_o, 0);
    tick();
    rst_i = 1'b0;

    // loopback 11,22,33,44
    inport_accept_i = 1'b1;
    send_byte(8'h11, 4, ok); check_eq("lb_ok0", ok, 1);
    send_byte(8'h22, 4, ok); check_eq("lb_ok1", ok, 1);
    send_byte(8'h33, 4, ok); check_eq("lb_ok2", ok, 1);
    send_byte(8'h44, 4, ok); check_eq("lb_ok3", ok, 1);
    repeat (6) tick();
    #2;
    check_seq("lb", 4, 8'h11, 8'h11);
    check_eq("lb_rx", rx_count_o, 4);
    check_eq("lb_tx", tx_count_o, 4);
    check_eq("lb_level", level_o, 0);

    // backpressure: 16 fill the FIFO, 17th stalls until the consumer drains
    tick();
    do_clear();
    out_q.delete();
    inport_accept_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h40 + 8'(i), 2, ok);
      check_eq("bp_fill_ok", ok, 1);
    end
    outport_valid_i = 1'b1;
    outport_data_i  = 8'h50;
    #2;
    check_eq("bp_level_full", level_o, 16);
    check_eq("bp_accept_full", outport_accept_o, 0);
    check_eq("bp_valid_full", inport_valid_o, 1);
    tick();
    inport_accept_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h50 + 8'(i), 5, ok);
      check_eq("bp_rest_ok", ok, 1);
    end
    repeat (25) tick();
    #2;
    check_seq("bp", 20, 8'h40, 8'h01);
    check_eq("bp_rx", rx_count_o, 20);
    check_eq("bp_tx", tx_count_o, 20);
    check_eq("bp_level", level_o, 0);

    // mode change to generator stalls both ports for one cycle
    tick();
    mode_i = 2'd1;
    #2;
    check_eq("mc_accept", outport_accept_o, 0);
    tick();
    #2;
    check_eq("mc_accept_after", outport_accept_o, 1);
    tick();
    do_clear();
    out_q.delete();

    // generator burst with a second start ignored
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    #2;
    check_eq("gen_busy", busy_o, 1);
    tick();
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    #2;
    check_seq("gen", 8, 8'h05, 8'h01);
    check_eq("gen_tx", tx_count_o, 8);
    check_eq("gen_busy_end", busy_o, 0);
    check_eq("gen_level", level_o, 0);
    tick();
    send_byte(8'hAA, 2, ok);
    repeat (2) tick();
    #2;
    check_eq("gen_rx_discard", rx_count_o, 1);
    check_eq("gen_no_echo", out_q.size(), 8);

    // checker
    tick();
    mode_i = 2'd2;
    tick();
    do_clear();
    send_byte(8'h05, 2, ok);
    send_byte(8'h06, 2, ok);
    send_byte(8'h08, 2, ok);
    send_byte(8'h09, 2, ok);
    #2;
    check_eq("chk_err1", err_count_o, 1);
    check_eq("chk_valid", inport_valid_o, 0);
    tick();
    send_byte(8'h0A, 2, ok);
    #2;
    check_eq("chk_resync", err_count_o, 1);
    tick();
    send_byte(8'hFE, 2, ok);
    send_byte(8'hFF, 2, ok);
    send_byte(8'h00, 2, ok);
    send_byte(8'h01, 2, ok);
    #2;
    check_eq("chk_wrap", err_count_o, 2);
    check_eq("chk_rx", rx_count_o, 9);

    // sink saturation and clear priority
    tick();
    mode_i = 2'd3;
    tick();
    do_clear();
    for (int i = 0; i < 40; i++) send_byte(8'(i), 2, ok);
    #2;
    check_eq("sink_sat", rx_count_o, 31);
    check_eq("sink_err", err_count_o, 0);
    check_eq("sink_level", level_o, 0);
    tick();
    clear_i = 1'b1;
    outport_valid_i = 1'b1;
    #2;
    check_eq("clr_xfer_accept", outport_accept_o, 1);
    tick();
    clear_i = 1'b0;
    outport_valid_i = 1'b0;
    #2;
    check_eq("clr_wins", rx_count_o, 0);
    tick();
    send_byte(8'h77, 2, ok);
    #2;
    check_eq("sink_after_clr", rx_count_o, 1);

    // mode change mid-generation
    tick();
    mode_i = 2'd1;
    tick();
    do_clear();
    out_q.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_out(3, 30);
    mode_i = 2'd0;
    tick();
    #2;
    check_eq("mcg_level", level_o, 0);
    check_eq("mcg_busy", busy_o, 0);
    repeat (20) tick();
    #2;
    check_seq("mcg", 3, 8'h05, 8'h01);
    check_eq("mcg_tx_kept", tx_count_o, 3);

    // reset mid-generation
    tick();
    mode_i = 2'd1;
    tick();
    do_clear();
    out_q.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_out(3, 30);
    rst_i = 1'b1;
    #2;
    check_eq("rg_accept", outport_accept_o, 0);
    check_eq("rg_valid", inport_valid_o, 0);
    tick();
    rst_i = 1'b0;
    #2;
    check_eq("rg_level", level_o, 0);
    check_eq("rg_busy", busy_o, 0);
    check_eq("rg_tx", tx_count_o, 0);
    repeat (20) tick();
    #2;
    check_seq("rg", 3, 8'h05, 8'h01);
    check_eq("rg_tx_end", tx_count_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
